// File: rtl/omsp_gfx_backend_pix_fetch.sv
// Frame-buffer fetch: Video-RAM words into a small FIFO, unpacked to 1/2/4/8/16 bpp pixels.
// Define OMSP_GFX_PIX_MSB_FIRST_EN to extract pixels MSB-first instead of LSB-first.
module omsp_gfx_backend_pix_fetch #(
  parameter int unsigned DW         = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned VRAM_AW    = 17,
  parameter int unsigned SPIX_W     = 17
) (
  input  logic               mclk,
  input  logic               puc_rst_n,
  input  logic               refresh_active_i,
  input  logic [VRAM_AW-1:0] refresh_frame_base_addr_i,
  input  logic [SPIX_W-1:0]  display_size_i,
  input  logic [2:0]         gfx_mode_i,
  input  logic [DW-1:0]      vid_ram_dout_i,
  input  logic               vid_ram_dout_rdy_nxt_i,
  output logic [VRAM_AW-1:0] vid_ram_addr_o,
  output logic               vid_ram_cen_o,
  input  logic               refresh_data_request_i,
  output logic [15:0]        pix_data_o,
  output logic               pix_is_index_o,
  output logic               pix_ready_o
);

  localparam int unsigned DwLog = $clog2(DW);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned SlotW = DwLog;

  typedef enum logic [1:0] {StIdle, StReq, StData} state_e;

  state_e             state, state_nxt;
  logic               active_q;
  logic [VRAM_AW-1:0] base_q;
  logic [SPIX_W-1:0]  word_cnt;
  logic [SPIX_W-1:0]  pix_cnt;
  logic [SlotW-1:0]   slot;
  logic               pending;
  logic [15:0]        pix_data;
  logic               pix_ready;
  logic               pix_is_index;

  logic [DW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr, rd_ptr;
  logic [CntW-1:0]    fifo_cnt, cnt_nxt;

  // Mode decode and frame geometry
  logic [2:0]         bpp_log, ppw_log;
  logic [4:0]         bpp;
  logic [SlotW-1:0]   ppw_m1;
  logic [SPIX_W:0]    words_rnd;
  logic [SPIX_W-1:0]  word_last, size_m1;

  always_comb begin
    bpp_log   = gfx_mode_i[2] ? 3'd4 : {1'b0, gfx_mode_i[1:0]};
    bpp       = 5'd1 << bpp_log;
    ppw_log   = 3'(DwLog) - bpp_log;
    ppw_m1    = SlotW'((DW >> bpp_log) - 1);
    words_rnd = ({1'b0, display_size_i} + (SPIX_W+1)'(ppw_m1)) >> ppw_log;
    word_last = SPIX_W'(words_rnd - (SPIX_W+1)'(1));
    size_m1   = display_size_i - SPIX_W'(1);
  end

  // FIFO control; an empty FIFO being written this cycle bypasses the write data to the unpacker
  logic          push, pop, fifo_empty, avail, serve, last_slot, last_pix;
  logic [DW-1:0] head, shifted;
  logic [SlotW-1:0] shamt;
  logic [15:0]   mask, pix_val;

  always_comb begin
    push       = (state == StData) && refresh_active_i;
    fifo_empty = (fifo_cnt == '0);
    avail      = !fifo_empty || push;
    head       = fifo_empty ? vid_ram_dout_i : fifo_mem[rd_ptr];
    serve      = refresh_active_i && avail && (refresh_data_request_i || pending);
    last_slot  = (slot == ppw_m1);
    last_pix   = (pix_cnt == size_m1);
    pop        = serve && (last_slot || last_pix);
    cnt_nxt    = fifo_cnt + CntW'(push) - CntW'(pop);
`ifdef OMSP_GFX_PIX_MSB_FIRST_EN
    shamt      = SlotW'((ppw_m1 - slot) << bpp_log);
`else
    shamt      = SlotW'(slot << bpp_log);
`endif
    shifted    = head >> shamt;
    mask       = ~(16'hFFFF << bpp);
    pix_val    = 16'(shifted & DW'(mask));
  end

  always_comb begin
    state_nxt = state;
    if (!refresh_active_i) begin
      state_nxt = StIdle;
    end else begin
      unique case (state)
        StIdle: if (display_size_i != '0 && fifo_cnt < CntW'(FIFO_DEPTH)) state_nxt = StReq;
        StReq:  if (vid_ram_dout_rdy_nxt_i) state_nxt = StData;
        StData: state_nxt = (cnt_nxt < CntW'(FIFO_DEPTH)) ? StReq : StIdle;
        default: state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) state <= StIdle;
    else            state <= state_nxt;
  end

  always_ff @(posedge mclk) begin
    if (push) fifo_mem[wr_ptr] <= vid_ram_dout_i;
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      active_q     <= 1'b0;
      base_q       <= '0;
      word_cnt     <= '0;
      pix_cnt      <= '0;
      slot         <= '0;
      pending      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      pix_data     <= '0;
      pix_ready    <= 1'b0;
      pix_is_index <= 1'b0;
    end else begin
      active_q  <= refresh_active_i;
      pix_ready <= serve;
      if (!refresh_active_i) begin
        // Abort: flush and rewind so the next refresh restarts at the frame base
        word_cnt <= '0;
        pix_cnt  <= '0;
        slot     <= '0;
        pending  <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (!active_q) base_q <= refresh_frame_base_addr_i;
        if (push) begin
          wr_ptr <= wr_ptr + PtrW'(1);
          if (word_cnt == word_last) begin
            word_cnt <= '0;
            base_q   <= refresh_frame_base_addr_i;
          end else begin
            word_cnt <= word_cnt + SPIX_W'(1);
          end
        end
        if (pop) rd_ptr <= rd_ptr + PtrW'(1);
        fifo_cnt <= cnt_nxt;
        if (serve) begin
          pix_data     <= pix_val;
          pix_is_index <= !gfx_mode_i[2];
          slot         <= pop ? '0 : slot + SlotW'(1);
          pix_cnt      <= last_pix ? '0 : pix_cnt + SPIX_W'(1);
          pending      <= 1'b0;
        end else if (refresh_data_request_i) begin
          pending <= 1'b1;
        end
      end
    end
  end

  assign vid_ram_cen_o  = (state != StReq);
  assign vid_ram_addr_o = base_q + VRAM_AW'(word_cnt);
  assign pix_data_o     = pix_data;
  assign pix_ready_o    = pix_ready;
  assign pix_is_index_o = pix_is_index;

endmodule

// File: tb/tb_omsp_gfx_backend_pix_fetch.sv
// Directed bench: DUT A is DW=16/FIFO_DEPTH=2 with addr^0xA5A5 RAM, DUT B is DW=32 with a fixed word.
module tb_omsp_gfx_backend_pix_fetch;

  logic mclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 mclk = ~mclk;

  // DUT A
  logic        a_active, a_rdy, a_cen, a_req, a_idx, a_ready, a_data;
  logic [16:0] a_base, a_size, a_addr, a_lat;
  logic [2:0]  a_mode;
  logic [15:0] a_dout, a_pix;
  int          a_stall, a_wait, a_reads;

  // DUT B
  logic        b_active, b_rdy, b_cen, b_req, b_idx, b_ready;
  logic [16:0] b_base, b_size, b_addr;
  logic [2:0]  b_mode;
  logic [31:0] b_dout;
  logic [15:0] b_pix;
  int          b_reads;

  int n_cmp = 0;
  int n_bad = 0;

  omsp_gfx_backend_pix_fetch #(.DW(16), .FIFO_DEPTH(2), .VRAM_AW(17), .SPIX_W(17)) u_dut_a (
    .mclk                      (mclk),
    .puc_rst_n                 (rst_n),
    .refresh_active_i          (a_active),
    .refresh_frame_base_addr_i (a_base),
    .display_size_i            (a_size),
    .gfx_mode_i                (a_mode),
    .vid_ram_dout_i            (a_dout),
    .vid_ram_dout_rdy_nxt_i    (a_rdy),
    .vid_ram_addr_o            (a_addr),
    .vid_ram_cen_o             (a_cen),
    .refresh_data_request_i    (a_req),
    .pix_data_o                (a_pix),
    .pix_is_index_o            (a_idx),
    .pix_ready_o               (a_ready)
  );

  omsp_gfx_backend_pix_fetch #(.DW(32), .FIFO_DEPTH(4), .VRAM_AW(17), .SPIX_W(17)) u_dut_b (
    .mclk                      (mclk),
    .puc_rst_n                 (rst_n),
    .refresh_active_i          (b_active),
    .refresh_frame_base_addr_i (b_base),
    .display_size_i            (b_size),
    .gfx_mode_i                (b_mode),
    .vid_ram_dout_i            (b_dout),
    .vid_ram_dout_rdy_nxt_i    (b_rdy),
    .vid_ram_addr_o            (b_addr),
    .vid_ram_cen_o             (b_cen),
    .refresh_data_request_i    (b_req),
    .pix_data_o                (b_pix),
    .pix_is_index_o            (b_idx),
    .pix_ready_o               (b_ready)
  );

  // RAM A: rdy_nxt a cycle after cen (plus a_stall cycles); a_data marks the DUT's write cycle
  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdy <= 1'b0; a_wait <= 0; a_data <= 1'b0; a_reads <= 0; a_lat <= '0;
    end else begin
      a_rdy  <= 1'b0;
      a_data <= a_rdy && !a_cen;
      if (a_rdy && !a_cen) a_reads <= a_reads + 1;
      if (!a_cen) begin
        a_lat <= a_addr;
        if (!a_rdy) begin
          if (a_wait >= a_stall) begin a_rdy <= 1'b1; a_wait <= 0; end
          else a_wait <= a_wait + 1;
        end
      end else begin
        a_wait <= 0;
      end
    end
  end
  assign a_dout = a_lat[15:0] ^ 16'hA5A5;

  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      b_rdy <= 1'b0; b_reads <= 0;
    end else begin
      b_rdy <= !b_cen && !b_rdy;
      if (b_rdy && !b_cen) b_reads <= b_reads + 1;
    end
  end
  assign b_dout = 32'h76543210;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Idle a while so prefetch settles, pulse one request, then expect the pixel next cycle
  task automatic pixel_req(input bit sel_b, input string tag, input logic [15:0] exp,
                           input logic exp_idx);
    int lat;
    repeat (8) @(negedge mclk);
    if (sel_b) b_req = 1'b1; else a_req = 1'b1;
    @(negedge mclk);
    a_req = 1'b0; b_req = 1'b0;
    lat = 0;
    while (!(sel_b ? b_ready : a_ready) && lat < 50) begin
      @(negedge mclk);
      lat++;
    end
    check_eq({tag, " latency"}, lat, 0);
    check_eq({tag, " data"}, sel_b ? b_pix : a_pix, exp);
    check_eq({tag, " is_index"}, sel_b ? b_idx : a_idx, exp_idx);
  endtask

  task automatic wait_cen_low(input string tag);
    int n;
    n = 0;
    while (a_cen && n < 20) begin
      @(negedge mclk);
      n++;
    end
    check_eq({tag, " cen low seen"}, a_cen, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] w, e16;
    int p, bitpos, snap, t_data, t_rdy;
    logic [15:0] stall_pix;

    a_active = 0; a_base = '0; a_size = '0; a_mode = '0; a_req = 0; a_stall = 0;
    b_active = 0; b_base = '0; b_size = '0; b_mode = '0; b_req = 0;
    repeat (3) @(negedge mclk);
    check_eq("rst a cen", a_cen, 1'b1);
    check_eq("rst a addr", a_addr, 17'h0);
    check_eq("rst a pix", a_pix, 16'h0);
    check_eq("rst a ready", a_ready, 1'b0);
    check_eq("rst a is_index", a_idx, 1'b0);
    check_eq("rst b cen", b_cen, 1'b1);
    check_eq("rst b pix", b_pix, 16'h0);
    rst_n = 1'b1;

    // 16bpp, 4-pixel frame at 0x100; depth-2 FIFO fills with exactly two reads
    @(negedge mclk);
    a_base = 17'h100; a_size = 17'd4; a_mode = 3'b100;
    a_active = 1'b1;
    repeat (12) @(negedge mclk);
    check_eq("fill reads", a_reads, 2);
    check_eq("fill cen idle", a_cen, 1'b1);
    pixel_req(1'b0, "p16_0", 16'hA4A5, 1'b0);
    repeat (10) @(negedge mclk);
    check_eq("refill reads", a_reads, 3);
    pixel_req(1'b0, "p16_1", 16'hA4A4, 1'b0);
    pixel_req(1'b0, "p16_2", 16'hA4A7, 1'b0);
    pixel_req(1'b0, "p16_3", 16'hA4A6, 1'b0);
    pixel_req(1'b0, "p16_wrap", 16'hA4A5, 1'b0);

    // Zero-size frame issues no reads
    a_active = 1'b0;
    @(negedge mclk);
    a_size = '0;
    snap = a_reads;
    a_active = 1'b1;
    repeat (20) @(negedge mclk);
    check_eq("size0 reads", a_reads, snap);
    check_eq("size0 cen", a_cen, 1'b1);
    a_active = 1'b0;

    // 1bpp, 20 pixels over two words; pixel 21 restarts at word 0 bit-slot 0
    @(negedge mclk);
    a_mode = 3'b000; a_size = 17'd20; a_base = 17'h100;
    a_active = 1'b1;
    for (int i = 0; i < 21; i++) begin
      p = i % 20;
      w = 16'(17'h100 + 17'(p / 16)) ^ 16'hA5A5;
`ifdef OMSP_GFX_PIX_MSB_FIRST_EN
      bitpos = 15 - (p % 16);
`else
      bitpos = p % 16;
`endif
      e16 = {15'b0, w[bitpos]};
      pixel_req(1'b0, $sformatf("p1_%0d", i), e16, 1'b1);
    end

    // Request with empty FIFO and a stalled RAM: ready one cycle after the data write
    a_active = 1'b0;
    @(negedge mclk);
    a_mode = 3'b100; a_size = 17'd4; a_base = 17'h100; a_stall = 5;
    a_active = 1'b1;
    a_req = 1'b1;
    t_data = -1; t_rdy = -1; stall_pix = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge mclk);
      a_req = 1'b0;
      if (a_data && t_data < 0) t_data = k;
      if (a_ready && t_rdy < 0) begin t_rdy = k; stall_pix = a_pix; end
    end
    check_eq("stall data seen", t_data >= 0, 1'b1);
    check_eq("stall ready latency", t_rdy - t_data, 1);
    check_eq("stall pix", stall_pix, 16'hA4A5);

    // Abort in REQ: cen released next cycle, FIFO flushed, restart at new base
    a_active = 1'b0;
    a_stall = 0;
    @(negedge mclk);
    a_active = 1'b1;
    repeat (12) @(negedge mclk);
    a_stall = 5;
    pixel_req(1'b0, "pre abort", 16'hA4A5, 1'b0);
    wait_cen_low("abort refetch");
    @(negedge mclk);
    a_active = 1'b0;
    @(negedge mclk);
    check_eq("abort cen", a_cen, 1'b1);
    a_base = 17'h200; a_stall = 0;
    a_active = 1'b1;
    wait_cen_low("restart");
    check_eq("restart addr", a_addr, 17'h200);
    pixel_req(1'b0, "restart pix", 16'hA7A5, 1'b0);

    // DW=32, 4bpp: one word yields 8 indices; only the final pixel pops it
    b_mode = 3'b010; b_size = 17'd8; b_base = 17'h40;
    b_active = 1'b1;
    repeat (15) @(negedge mclk);
    check_eq("b fill reads", b_reads, 4);
    snap = b_reads;
    for (int i = 0; i < 7; i++) begin
`ifdef OMSP_GFX_PIX_MSB_FIRST_EN
      e16 = 16'(7 - i);
`else
      e16 = 16'(i);
`endif
      pixel_req(1'b1, $sformatf("p4_%0d", i), e16, 1'b1);
    end
    repeat (10) @(negedge mclk);
    check_eq("b reads after 7", b_reads, snap);
`ifdef OMSP_GFX_PIX_MSB_FIRST_EN
    pixel_req(1'b1, "p4_7", 16'd0, 1'b1);
`else
    pixel_req(1'b1, "p4_7", 16'd7, 1'b1);
`endif
    repeat (10) @(negedge mclk);
    check_eq("b reads after 8", b_reads, snap + 1);
    check_eq("b addr", b_addr, 17'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
